data_ram: RTL and testbench

Byte-addressable data memory with a built-in RISC-V style load/store datapath. It sits behind the execute stage. Each start pulse performs one operation:
- computes the effective address from a base operand and an immediate;
- performs a byte, halfword or word load (with sign/zero extension) or store;
- reports completion with a one-cycle `done` pulse and a 32-bit result.

---
 rtl/data_ram.sv | 115 +++++++++++
 tb/tb_data_ram.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Byte-addressable data memory with a RISC-V load/store datapath.
// One operation per start pulse, one-cycle latency, registered done/res.
module data_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] imm_data,
  input  logic        start,
  input  logic [1:0]  use_part,
  input  logic [1:0]  op_mode1,
  input  logic [2:0]  op_mode2,
  output logic        done,
  output logic [31:0] res
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] UP_LOAD  = 2'b01;
  localparam logic [1:0] UP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [DW-1:0] mem [DEPTH_WORDS];

  logic [DW-1:0] ea;
  logic [AW-1:0] widx;
  logic [DW-1:0] rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [DW-1:0] load_val;
  logic [DW-1:0] wr_word;
  logic          wr_en;
  logic          is_load;
  logic          is_store;

  // Effective address; op_mode1 = 01 bypasses the offset, 1x behaves like 00.
  always_comb begin
    ea = (op_mode1 == 2'b01) ? op1 : DW'(op1 + imm_data);
  end

  assign widx     = ea[AW+1:2];
  assign rd_word  = mem[widx];
  assign is_load  = (use_part == UP_LOAD);
  assign is_store = (use_part == UP_STORE);

  // Lane extraction and sign/zero extension for loads.
  always_comb begin
    byte_v   = rd_word[{ea[1:0], 3'b000} +: 8];
    half_v   = ea[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (op_mode2)
      F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_val = {{16{half_v[15]}}, half_v};
      F3_W:    load_val = rd_word;
      F3_BU:   load_val = {24'd0, byte_v};
      F3_HU:   load_val = {16'd0, half_v};
      default: load_val = '0;
    endcase
  end

  // Read-modify-write merge so unaddressed lanes keep their contents.
  always_comb begin
    wr_word = rd_word;
    wr_en   = 1'b0;
    case (op_mode2)
      F3_B: begin
        wr_word[{ea[1:0], 3'b000} +: 8] = op2[7:0];
        wr_en = 1'b1;
      end
      F3_H: begin
        wr_word[{ea[1], 4'b0000} +: 16] = op2[15:0];
        wr_en = 1'b1;
      end
      F3_W: begin
        wr_word = op2;
        wr_en   = 1'b1;
      end
      default: begin
        wr_word = rd_word;
        wr_en   = 1'b0;
      end
    endcase
  end

  // Reset clears the array and wins over a coincident request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done <= 1'b0;
      res  <= '0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else begin
      done <= start;
      if (start && is_load) begin
        res <= load_val;
      end
      if (start && is_store) begin
        res <= ea;
        if (wr_en) begin
          mem[widx] <= wr_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: table of single-op vectors plus
// back-to-back and reset-collision sequences.
module tb_data_ram;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] imm_data;
  logic        start;
  logic [1:0]  use_part;
  logic [1:0]  op_mode1;
  logic [2:0]  op_mode2;
  logic        done;
  logic [31:0] res;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0]  up;
    logic [1:0]  m1;
    logic [2:0]  m2;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] imm;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  data_ram #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .imm_data(imm_data),
    .start(start), .use_part(use_part), .op_mode1(op_mode1),
    .op_mode2(op_mode2), .done(done), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] up, input logic [1:0] m1, input logic [2:0] m2,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] imm,
                     input logic [31:0] exp_res);
    vec_t v;
    v.up = up; v.m1 = m1; v.m2 = m2; v.a = a; v.d = d; v.imm = imm; v.exp_res = exp_res;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] up, input logic [1:0] m1, input logic [2:0] m2,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] imm);
    use_part = up; op_mode1 = m1; op_mode2 = m2;
    op1 = a; op2 = d; imm_data = imm; start = 1'b1;
  endtask

  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] ST = 2'b10;

  initial begin
    rst = 1'b0; start = 1'b0; op1 = '0; op2 = '0; imm_data = '0;
    use_part = '0; op_mode1 = '0; op_mode2 = '0;

    //   up  m1     m2      op1           op2           imm           expected res
    add(LD, 2'b00, 3'b010, 32'h0,        32'h0,        32'h1,        32'h0000_0000);
    add(ST, 2'b00, 3'b010, 32'h0,        32'hFFFF_FFFF, 32'h4,       32'h0000_0004);
    add(LD, 2'b00, 3'b010, 32'h4,        32'h0,        32'h0,        32'hFFFF_FFFF);
    add(LD, 2'b00, 3'b100, 32'h5,        32'h0,        32'h0,        32'h0000_00FF);
    add(LD, 2'b00, 3'b000, 32'h5,        32'h0,        32'h0,        32'hFFFF_FFFF);
    add(ST, 2'b00, 3'b010, 32'h8,        32'h1234_8678, 32'h0,       32'h0000_0008);
    add(LD, 2'b00, 3'b001, 32'h8,        32'h0,        32'h0,        32'hFFFF_8678);
    add(LD, 2'b00, 3'b101, 32'hA,        32'h0,        32'h0,        32'h0000_1234);
    add(ST, 2'b00, 3'b000, 32'h9,        32'hFFFF_FFAB, 32'h0,       32'h0000_0009);
    add(LD, 2'b00, 3'b010, 32'h8,        32'h0,        32'h0,        32'h1234_AB78);
    add(ST, 2'b00, 3'b010, 32'h400,      32'hCAFE_0001, 32'hC,       32'h0000_040C);
    add(LD, 2'b00, 3'b010, 32'h10,       32'h0,        32'hFFFF_FFFC, 32'hCAFE_0001);
    add(LD, 2'b01, 3'b010, 32'hC,        32'h0,        32'h100,      32'hCAFE_0001);
    add(LD, 2'b11, 3'b010, 32'h8,        32'h0,        32'h4,        32'hCAFE_0001);
    add(ST, 2'b00, 3'b001, 32'hE,        32'h5555_BEEF, 32'h0,       32'h0000_000E);
    add(LD, 2'b00, 3'b010, 32'hC,        32'h0,        32'h0,        32'hBEEF_0001);
    add(LD, 2'b00, 3'b001, 32'hF,        32'h0,        32'h0,        32'hFFFF_BEEF);
    add(ST, 2'b00, 3'b100, 32'hC,        32'h0,        32'h0,        32'h0000_000C);
    add(LD, 2'b00, 3'b010, 32'hC,        32'h0,        32'h0,        32'hBEEF_0001);
    add(LD, 2'b00, 3'b011, 32'hC,        32'h0,        32'h0,        32'h0000_0000);
    add(LD, 2'b00, 3'b000, 32'h9,        32'h0,        32'h0,        32'hFFFF_FFAB);
    add(LD, 2'b00, 3'b100, 32'hB,        32'h0,        32'h0,        32'h0000_0012);
    add(LD, 2'b00, 3'b101, 32'h6,        32'h0,        32'h0,        32'h0000_FFFF);
    add(2'b00, 2'b00, 3'b010, 32'h8,     32'h0,        32'h0,        32'h0000_FFFF);
    add(2'b11, 2'b00, 3'b010, 32'h8,     32'h0,        32'h0,        32'h0000_FFFF);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].up, vecs[i].m1, vecs[i].m2, vecs[i].a, vecs[i].d, vecs[i].imm);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk($sformatf("vec%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_idle_done", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_idle_res", i), res, vecs[i].exp_res);
    end

    // Back-to-back: store, load, no-op with start held high
    @(negedge clk);
    drive(ST, 2'b00, 3'b010, 32'h20, 32'hA5A5_5A5A, 32'h0);
    @(posedge clk); #1;
    chk("b2b_sw_done", {31'd0, done}, 32'd1);
    chk("b2b_sw_res", res, 32'h0000_0020);
    @(negedge clk);
    drive(LD, 2'b00, 3'b010, 32'h1C, 32'h0, 32'h4);
    @(posedge clk); #1;
    chk("b2b_lw_done", {31'd0, done}, 32'd1);
    chk("b2b_lw_res", res, 32'hA5A5_5A5A);
    @(negedge clk);
    drive(2'b00, 2'b00, 3'b010, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("b2b_nop_done", {31'd0, done}, 32'd1);
    chk("b2b_nop_res", res, 32'hA5A5_5A5A);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", {31'd0, done}, 32'd0);
    chk("b2b_end_res", res, 32'hA5A5_5A5A);

    // Reset coinciding with a store request
    @(negedge clk);
    drive(ST, 2'b00, 3'b010, 32'h30, 32'h1111_2222, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstcol_done", {31'd0, done}, 32'd0);
    chk("rstcol_res", res, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rstcol_idle_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    drive(LD, 2'b00, 3'b010, 32'h30, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rstcol_ld30_done", {31'd0, done}, 32'd1);
    chk("rstcol_ld30_res", res, 32'd0);
    @(negedge clk);
    drive(LD, 2'b00, 3'b010, 32'h8, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rstcol_ld8_res", res, 32'd0);
    @(negedge clk);
    drive(LD, 2'b00, 3'b010, 32'h20, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rstcol_ld20_res", res, 32'd0);
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
